spi_slave_regbus: RTL
=====================

// Module: spi_slave_regbus
// PURPOSE
//  SPI-mode-0 slave that terminates the frames issued by the SPI master and turns
//  them into single-cycle accesses on a local register bus (dram-style port).
//  It is the far end of the I2C->SPI bridge: it decodes one header byte (R/W + addr)
//  and then writes or reads one data word. All logic runs on i_ck; the SPI pins are
//  oversampled.
// PARAMETERS
//  DW   8  data word width; frame data phase length in bits
//  AW   4  register address width; AW <= 7 (header is always 8 bits)
// PORTS
//  i_ck         in   1   system clock; must run >= 6x the SCLK phase rate
//  i_rstn       in   1   reset, asynchronous, active-low
//  i_sclk       in   1   SPI clock, CPOL=0, async to i_ck
//  i_csn        in   1   SPI chip select, active-low, async to i_ck
//  i_mosi       in   1   SPI data in, MSB first
//  o_miso       out  1   SPI data out, MSB first
//  o_miso_oe    out  1   1 while i_csn is low (pad tri-state enable)
//  o_address    out  AW  register bus address
//  o_wdata      out  DW  register bus write data
//  o_rw         out  1   1 = read, 0 = write; qualified by o_en
//  o_en         out  1   one-cycle access strobe
//  i_rdata      in   DW  register bus read data, valid 1 cycle after read strobe
//  o_busy       out  1   frame in progress (CSN low, sync'd)
//  o_frame_err  out  1   one-cycle pulse: frame aborted before bit 8+DW
// BEHAVIOUR
//  Frame: header[7]=R/W (1=read), header[6:AW]=reserved (ignored), header[AW-1:0]=addr,
//   followed by DW data bits. Mode 0: sample MOSI on SCLK rise, drive MISO on fall.
//  Sync: SCLK, CSN, MOSI each through 2-FF synchronizer; edge detect adds 1 flop.
//   An SCLK edge is acted on 3 i_ck after the pin edge. MOSI is sampled on the same
//   synced cycle the rise is detected.
//  Reset: all outputs 0; o_miso=0; state IDLE; bit counter 0.
//  FSM: IDLE -> HDR on synced CSN fall (bit cnt cleared).
//   HDR: shift in 8 bits. On 8th rise: latch rw/addr; if read, assert o_en=1,o_rw=1
//    next cycle, load i_rdata into TX shift reg on the following cycle -> DATA.
//    If write -> DATA with TX reg = 0.
//   DATA: each rise shifts MOSI into RX reg; each fall presents next TX bit on o_miso
//    (the first data fall presents TX[DW-1]). On rise DW: if write, o_en=1,o_rw=0,
//    o_wdata=RX, o_address=addr for exactly 1 cycle -> DONE. If read -> DONE.
//   DONE: further SCLK edges ignored, o_miso=0; wait for CSN rise -> IDLE.
//  o_address/o_wdata hold last value between strobes; o_en never asserted otherwise.
//  Boundaries:
//   - CSN rise in HDR or DATA (before rise 8+DW): abort, no write strobe, o_frame_err
//     pulse 1 cycle, -> IDLE. A read strobe already issued is not retracted.
//   - CSN rise in DONE or IDLE: no error.
//   - SCLK edges while CSN high: ignored.
//   - CSN fall and SCLK rise detected in the same cycle: CSN wins, edge discarded.
//   - >8+DW clocks in one frame: extras ignored, MISO 0, no second access.
//   - reset mid-frame: immediate return to reset state, no strobe.
//  o_miso_oe = ~csn_sync; o_busy = (state != IDLE).
// STRUCTURE
//  Shared package/include: SPI frame constants (HDR_BITS=8, RW bit index=7), FSM state
//   encodings IDLE/HDR/DATA/DONE.
//  One sub-module: spi_pin_sync (2-FF sync + rise/fall detect for SCLK, CSN, MOSI).
//  Top holds FSM, bit counter (width clog2(8+DW)), RX/TX shift regs, bus outputs.
// TESTING
//  Write: CSN low, send 0x03,0xA5 (SCLK phase 20 i_ck) -> one o_en, o_rw=0, addr=3,
//   wdata=0xA5 after 16th rise; o_frame_err stays 0.
//  Read: send 0x85, i_rdata=0x3C on strobe -> o_en,o_rw=1,addr=5 once after 8th rise;
//   MISO bits on data phase = 0x3C MSB first.
//  Abort: send 0x02 then 3 data bits, raise CSN -> no write strobe, o_frame_err=1 once.
//  Overclock: 0x01,0x5A then 8 extra clocks -> exactly one write of 0x5A, MISO 0 after.
//  Reset mid-frame: assert i_rstn low after 10 bits -> all outputs 0; next full frame
//   0x04,0x11 writes addr 4 data 0x11 correctly.
//  Back-to-back: two frames with CSN high 4 SCLK phases between -> two correct strobes.

Source files
------------

// File: rtl/spi_slave_regbus_pkg.sv
// Shared SPI frame constants and slave FSM state encodings.
// Imported by the pin synchronizer and the regbus slave top.
package spi_slave_regbus_pkg;

    localparam int HDR_BITS = 8;
    localparam int RW_BIT   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_slave_regbus_pin_sync.sv
// Two-flop synchronizers for SCLK, CSN and MOSI, plus an extra flop on SCLK/CSN
// for rise/fall detection. Pin order in the vectors: {mosi, csn, sclk}.
module spi_pin_sync (
    input  logic i_ck,
    input  logic i_rstn,
    input  logic i_sclk,
    input  logic i_csn,
    input  logic i_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_rise,
    output logic csn_fall,
    output logic csn_sync,
    output logic mosi_sync
);

    // CSN idles high so no spurious frame start appears right after reset.
    localparam logic [2:0] RST_VAL = 3'b010;

    logic [2:0] pin_in;
    logic [2:0] sync_vec;
    logic [1:0] dly_vec;

    assign pin_in = {i_mosi, i_csn, i_sclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            always_ff @(posedge i_ck or negedge i_rstn) begin
                if (!i_rstn) begin
                    s1_reg <= RST_VAL[gi];
                    s2_reg <= RST_VAL[gi];
                end else begin
                    s1_reg <= pin_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_vec[gi] = s2_reg;

            if (gi < 2) begin : g_edge
                logic s3_reg;
                always_ff @(posedge i_ck or negedge i_rstn) begin
                    if (!i_rstn) s3_reg <= RST_VAL[gi];
                    else         s3_reg <= s2_reg;
                end
                assign dly_vec[gi] = s3_reg;
            end
        end
    endgenerate

    assign sclk_rise = sync_vec[0] & ~dly_vec[0];
    assign sclk_fall = ~sync_vec[0] & dly_vec[0];
    assign csn_rise  = sync_vec[1] & ~dly_vec[1];
    assign csn_fall  = ~sync_vec[1] & dly_vec[1];
    assign csn_sync  = sync_vec[1];
    assign mosi_sync = sync_vec[2];

endmodule

// File: rtl/spi_slave_regbus.sv
// SPI mode-0 slave: one header byte (R/W + address) then one DW-bit data word,
// turned into a single-cycle access on a local register bus.
module spi_slave_regbus
    import spi_slave_regbus_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_ck,
    input  logic          i_rstn,
    input  logic          i_sclk,
    input  logic          i_csn,
    input  logic          i_mosi,
    output logic          o_miso,
    output logic          o_miso_oe,
    output logic [AW-1:0] o_address,
    output logic [DW-1:0] o_wdata,
    output logic          o_rw,
    output logic          o_en,
    input  logic [DW-1:0] i_rdata,
    output logic          o_busy,
    output logic          o_frame_err
);

    localparam int CW = $clog2(HDR_BITS + DW);
    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(HDR_BITS + DW - 1);

    logic sclk_rise, sclk_fall, csn_rise, csn_fall, csn_sync, mosi_sync;

    spi_pin_sync u_pin_sync (
        .i_ck      (i_ck),
        .i_rstn    (i_rstn),
        .i_sclk    (i_sclk),
        .i_csn     (i_csn),
        .i_mosi    (i_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_rise  (csn_rise),
        .csn_fall  (csn_fall),
        .csn_sync  (csn_sync),
        .mosi_sync (mosi_sync)
    );

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic          rw_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-2:0] rx_reg;
    logic [DW-1:0] tx_reg;
    logic          rd_load_reg;
    logic          miso_reg, en_reg, rw_out_reg, frame_err_reg;
    logic [AW-1:0] address_reg;
    logic [DW-1:0] wdata_reg;

    logic          start_frame, hdr_rise, data_rise, data_fall;
    logic          hdr_done, data_done, abort, rd_strobe, wr_strobe;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] rx_next;

    // The address shifter sees every header bit; after bit 8 only the low AW remain.
    assign addr_next = {addr_reg[AW-2:0], mosi_sync};
    assign rx_next   = {rx_reg, mosi_sync};

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (csn_fall) state_next = ST_HDR;
            ST_HDR:  if (csn_rise) state_next = ST_IDLE;
                     else if (hdr_done) state_next = ST_DATA;
            ST_DATA: if (csn_rise) state_next = ST_IDLE;
                     else if (data_done) state_next = ST_DONE;
            ST_DONE: if (csn_rise) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A CSN rise always beats an SCLK edge detected in the same cycle.
    always_comb begin
        start_frame = (state_reg == ST_IDLE) && csn_fall;
        hdr_rise    = (state_reg == ST_HDR)  && sclk_rise && !csn_rise;
        data_rise   = (state_reg == ST_DATA) && sclk_rise && !csn_rise;
        data_fall   = (state_reg == ST_DATA) && sclk_fall && !csn_rise;
        hdr_done    = hdr_rise  && (cnt_reg == HDR_LAST);
        data_done   = data_rise && (cnt_reg == DATA_LAST);
        abort       = ((state_reg == ST_HDR) || (state_reg == ST_DATA)) && csn_rise;
        rd_strobe   = hdr_done  && rw_reg;
        wr_strobe   = data_done && !rw_reg;
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_reg       <= '0;
            rw_reg        <= 1'b0;
            addr_reg      <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            rd_load_reg   <= 1'b0;
            miso_reg      <= 1'b0;
            en_reg        <= 1'b0;
            rw_out_reg    <= 1'b0;
            address_reg   <= '0;
            wdata_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            en_reg        <= rd_strobe | wr_strobe;
            frame_err_reg <= abort;
            // Read data arrives one cycle after the strobe, so load one cycle later.
            rd_load_reg   <= en_reg & rw_out_reg;

            if (start_frame)                cnt_reg <= '0;
            else if (hdr_rise || data_rise) cnt_reg <= cnt_reg + 1'b1;

            if (hdr_rise) begin
                addr_reg <= addr_next;
                if (cnt_reg == '0) rw_reg <= mosi_sync;
            end
            if (data_rise) rx_reg <= rx_next[DW-2:0];

            if (rd_load_reg)                                 tx_reg <= i_rdata;
            else if (data_fall)                              tx_reg <= {tx_reg[DW-2:0], 1'b0};
            else if (start_frame || (hdr_done && !rw_reg))   tx_reg <= '0;

            if (data_fall)                                   miso_reg <= tx_reg[DW-1];
            else if (data_done || abort || start_frame)      miso_reg <= 1'b0;

            if (rd_strobe) begin
                rw_out_reg  <= 1'b1;
                address_reg <= addr_next;
            end else if (wr_strobe) begin
                rw_out_reg  <= 1'b0;
                address_reg <= addr_reg;
                wdata_reg   <= rx_next;
            end
        end
    end

    assign o_miso      = miso_reg;
    assign o_miso_oe   = ~csn_sync;
    assign o_address   = address_reg;
    assign o_wdata     = wdata_reg;
    assign o_rw        = rw_out_reg;
    assign o_en        = en_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_frame_err = frame_err_reg;

endmodule
